alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Initiator-side sequencer for the combinational ALU (ports SrcA, SrcB, ALUControl, ALUResult, Zero).
- Buffers operation commands in a small FIFO, drives one operation at a time onto the ALU, registers the ALU's result and zero flag, and returns them on a valid/ready response channel.
- Sits between a command source (test sequencer or a future multi-cycle datapath controller) and the ALU instance.

Parameters:
- WIDTH, 8, operand/result width in bits.
- DEPTH, 4, command FIFO entries; power of two, at least 2.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  FIFO can accept a command
- cmd_op  input  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 OR
- cmd_a  input  WIDTH  operand A
- cmd_b  input  WIDTH  operand B
- alu_src_a  output  WIDTH  drives ALU SrcA
- alu_src_b  output  WIDTH  drives ALU SrcB
- alu_control  output  2  drives ALU ALUControl
- alu_result  input  WIDTH  from ALU ALUResult
- alu_zero  input  1  from ALU Zero
- rsp_valid  output  1  response held
- rsp_ready  input  1  response consumer ready
- rsp_result  output  WIDTH  captured ALU result
- rsp_zero  output  1  captured zero flag
- cmd_count  output  $clog2(DEPTH)+1  FIFO occupancy
- chk_err  output  1  sticky model mismatch (see Optional Feature)

Behaviour:
- Reset (async, active-high): FIFO emptied, pointers 0, state IDLE, all outputs 0 (cmd_ready becomes 1 once reset deasserts).
- Push when cmd_valid && cmd_ready.
- cmd_ready = (cmd_count != DEPTH). No push-through when full, even if a pop happens in the same cycle.
- Pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty and wraps naturally.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into operand registers at the edge and go to DRIVE.
  - DRIVE: operand registers appear on alu_src_a, alu_src_b and alu_control for exactly this cycle. At the closing edge, capture alu_result and alu_zero into rsp_result and rsp_zero, set rsp_valid, and go to HOLD.
  - HOLD: rsp_valid=1. rsp_result and rsp_zero are stable until rsp_valid && rsp_ready. On that handshake, clear rsp_valid. If the FIFO is non-empty, pop and go to DRIVE; otherwise go to IDLE.
- ALU drive outputs are registers; they hold their last values outside DRIVE.
- Latency: command accepted at edge E0 → popped at E1 → captured at E2. rsp_valid is high from E2, i.e. 2 cycles after acceptance.
- Maximum throughput is one response per 2 cycles.
- Push and pop in the same cycle: cmd_count is unchanged.
- Responses are returned strictly in command order.
- Reset mid-operation discards queued commands and any in-flight or held response. rsp_valid drops asynchronously, and no stale response appears after reset.
- Arithmetic is performed by the external ALU. This block adds no width extension; results are modulo 2^WIDTH.

Optional Feature:
- ALU_ISSUE_CHECK_EN defined:
  - Internal reference model computes the expected result during DRIVE: A+B, A-B, A&B or A|B, each modulo 2^WIDTH, with zero = (result==0).
  - At the capture edge, any mismatch with alu_result or alu_zero sets chk_err. chk_err stays set until reset.
- Not defined: no model logic; chk_err tied to 0.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum: ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_OR=2'b11.
  - issue_state_e enum: IDLE, DRIVE, HOLD.
  - ALU_WIDTH_DEF=8.
- Sub-module alu_cmd_fifo:
  - Parameterized on DEPTH and entry width 2+2*WIDTH.
  - Provides push/pop/full/empty/count.
- FSM and optional checker stay in alu_issue.

Test Plan (WIDTH=8, DEPTH=4, real ALU connected unless stated):
- Reset, then ADD a=0x41 b=0x02 → in the DRIVE cycle alu_src_a=0x41, alu_src_b=0x02, alu_control=00; rsp_result=0x43, rsp_zero=0, with rsp_valid high 2 cycles after acceptance.
- SUB 0x05,0x05 then SUB 0x01,0x0A → responses 0x00/zero=1, then 0xF7/zero=0, in order.
- rsp_ready=0, offer 7 commands → 5 accepted (1 in HOLD, 4 queued), cmd_ready=0 and cmd_count=4; raise rsp_ready → all 5 results drain in order, cmd_ready returns.
- rsp_ready=1, 3 AND/OR commands preloaded (0xF0&0x3C=0x30, 0xF0|0x0F=0xFF, 0x00&0xFF=0x00 zero=1) → rsp_valid pulses every other cycle.
- Assert reset while in HOLD with 2 queued → rsp_valid=0 immediately, cmd_count=0; after release, no response without a new command.
- ALU_ISSUE_CHECK_EN defined, ALU stub returning result^0x01 → chk_err rises at the first capture edge and stays high; macro undefined → chk_err stays 0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// alu_pkg : shared operation/state enums for the ALU issue sequencer.
// Rev 1.0
// ----------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } issue_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------
// alu_cmd_fifo : power-of-two command FIFO with occupancy count.
// Rev 1.0
// ----------------------------------------------------------------------
module alu_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 18
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic          push_ok;
  logic          pop_ok;

  // Pointer MSB is the lap bit: equal indices with differing MSB means full.
  assign count    = wr_ptr_q - rd_ptr_q;
  assign full     = (count == PW'(DEPTH));
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];
  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ----------------------------------------------------------------------
// alu_issue : queues ALU commands, drives one per op onto the external
// ALU, returns captured result/zero on a valid/ready response channel.
// Optional self-check model enabled by defining ALU_ISSUE_CHECK_EN.
// Rev 1.0
// ----------------------------------------------------------------------
module alu_issue
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEF,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [WIDTH-1:0]       cmd_a,
  input  logic [WIDTH-1:0]       cmd_b,
  output logic [WIDTH-1:0]       alu_src_a,
  output logic [WIDTH-1:0]       alu_src_b,
  output logic [1:0]             alu_control,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic                   alu_zero,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_zero,
  output logic [$clog2(DEPTH):0] cmd_count,
  output logic                   chk_err
);

  localparam int EW = 2 + 2 * WIDTH;

  issue_state_e     state_q, state_d;
  alu_op_e          op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_zero_q, rsp_zero_d;

  logic             fifo_push;
  logic             fifo_pop;
  logic [EW-1:0]    fifo_head;
  logic             fifo_full;
  logic             fifo_empty;

  // Ready is held low while reset is asserted so nothing is accepted into a clearing queue.
  assign cmd_ready = ~fifo_full & ~reset;
  assign fifo_push = cmd_valid & cmd_ready;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .DW    (EW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data ({cmd_op, cmd_a, cmd_b}),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (cmd_count)
  );

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;
    fifo_pop     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        rsp_result_d = alu_result;
        rsp_zero_d   = alu_zero;
        rsp_valid_d  = 1'b1;
        state_d      = HOLD;
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = DRIVE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (fifo_pop) begin
      op_d = alu_op_e'(fifo_head[EW-1 -: 2]);
      a_d  = fifo_head[2*WIDTH-1 -: WIDTH];
      b_d  = fifo_head[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= ALU_ADD;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign alu_src_a   = a_q;
  assign alu_src_b   = b_q;
  assign alu_control = op_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_zero    = rsp_zero_q;

`ifdef ALU_ISSUE_CHECK_EN
  logic [WIDTH-1:0] model_result;
  logic             chk_err_q, chk_err_d;

  always_comb begin
    model_result = '0;
    case (op_q)
      ALU_ADD: model_result = a_q + b_q;
      ALU_SUB: model_result = a_q - b_q;
      ALU_AND: model_result = a_q & b_q;
      ALU_OR:  model_result = a_q | b_q;
      default: model_result = '0;
    endcase
    chk_err_d = chk_err_q;
    if ((state_q == DRIVE) &&
        ((alu_result != model_result) || (alu_zero != (model_result == '0)))) begin
      chk_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      chk_err_q <= 1'b0;
    end else begin
      chk_err_q <= chk_err_d;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// tb_alu_issue : scoreboard bench for alu_issue with a behavioural ALU attached.
module tb_alu_issue;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_a, cmd_b;
  logic [7:0] alu_src_a, alu_src_b;
  logic [1:0] alu_control;
  logic [7:0] alu_result;
  logic       alu_zero;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_zero;
  logic [2:0] cmd_count;
  logic       chk_err;
  logic       alu_fault;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];   // {zero, result}

  always #5 clk = ~clk;

  alu_issue #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .cmd_count(cmd_count), .chk_err(chk_err)
  );

  // External ALU; alu_fault turns it into the result^1 stub.
  always_comb begin
    case (alu_control)
      2'b00:   alu_result = alu_src_a + alu_src_b;
      2'b01:   alu_result = alu_src_a - alu_src_b;
      2'b10:   alu_result = alu_src_a & alu_src_b;
      default: alu_result = alu_src_a | alu_src_b;
    endcase
    alu_result = alu_result ^ {7'b0, alu_fault};
  end
  assign alu_zero = (alu_result == 8'h00);

  function automatic logic [8:0] model(input logic [1:0] op, input int a, input int b, input bit flt);
    int r;
    case (op)
      2'd0:    r = (a + b) % 256;
      2'd1:    r = (a - b + 256) % 256;
      2'd2:    r = a & b;
      default: r = a | b;
    endcase
    if (flt) r = r ^ 1;
    return {(r == 0), 8'(r)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: compares every held response against the queue head, pops on handshake.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
    end else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("stale_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          chk("rsp_result", 32'(rsp_result), 32'(exp_q[0][7:0]));
          chk("rsp_zero", 32'(rsp_zero), 32'(exp_q[0][8]));
          if (rsp_ready) void'(exp_q.pop_front());
        end
      end
      if (cmd_valid && cmd_ready)
        exp_q.push_back(model(cmd_op, int'(cmd_a), int'(cmd_b), alu_fault));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                      input int budget, input bit rand_rdy, output bit ok);
    ok        = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    for (int i = 0; i < budget && !ok; i++) begin
      if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
      ok = cmd_ready;
      cycle();
    end
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    rsp_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (exp_q.size() == 0 && !rsp_valid) break;
      cycle();
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc;
    logic exp_chk;
`ifdef ALU_ISSUE_CHECK_EN
    exp_chk = 1'b1;
`else
    exp_chk = 1'b0;
`endif
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = '0; cmd_b = '0;
    rsp_ready = 1'b1; alu_fault = 1'b0;
    repeat (3) cycle();
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    chk("reset_cmd_ready", 32'(cmd_ready), 0);
    chk("reset_count", 32'(cmd_count), 0);
    chk("reset_src_a", 32'(alu_src_a), 0);
    chk("reset_chk_err", 32'(chk_err), 0);
    reset = 1'b0;
    #1;
    chk("post_reset_ready", 32'(cmd_ready), 1);

    // ADD latency and drive-cycle contents
    send(2'b00, 8'h41, 8'h02, 5, 1'b0, ok);
    chk("add_accept", 32'(ok), 1);
    chk("add_valid_e0", 32'(rsp_valid), 0);
    cycle();
    chk("drive_src_a", 32'(alu_src_a), 32'h41);
    chk("drive_src_b", 32'(alu_src_b), 32'h02);
    chk("drive_ctrl", 32'(alu_control), 0);
    chk("add_valid_e1", 32'(rsp_valid), 0);
    cycle();
    chk("add_valid_e2", 32'(rsp_valid), 1);
    chk("add_result", 32'(rsp_result), 32'h43);
    drain("drain_add");

    // SUB pair in order
    send(2'b01, 8'h05, 8'h05, 5, 1'b0, ok);
    send(2'b01, 8'h01, 8'h0A, 5, 1'b0, ok);
    drain("drain_sub");

    // Backpressure fill
    rsp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 7; i++) begin
      send(2'(i), 8'(8'h10 * i + 3), 8'(i + 1), 3, 1'b0, ok);
      if (ok) acc++;
    end
    chk("fill_accepted", 32'(acc), 5);
    chk("fill_ready", 32'(cmd_ready), 0);
    chk("fill_count", 32'(cmd_count), 4);
    drain("drain_fill");
    chk("fill_ready_back", 32'(cmd_ready), 1);
    chk("fill_count_empty", 32'(cmd_count), 0);

    // Back-to-back AND/OR: valid every other cycle
    rsp_ready = 1'b1;
    send(2'b10, 8'hF0, 8'h3C, 5, 1'b0, ok);
    send(2'b11, 8'hF0, 8'h0F, 5, 1'b0, ok);
    send(2'b10, 8'h00, 8'hFF, 5, 1'b0, ok);
    for (int i = 0; i < 5; i++) begin
      chk("pulse_pattern", 32'(rsp_valid), 32'((i % 2) == 0));
      cycle();
    end
    drain("drain_pulse");

    // Randomized traffic with random response backpressure
    for (int n = 0; n < 40; n++) begin
      send(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), 50, 1'b1, ok);
      chk("rand_accept", 32'(ok), 1);
    end
    drain("drain_rand");
    chk("chk_err_clean", 32'(chk_err), 0);

    // Reset while holding with two queued
    rsp_ready = 1'b0;
    send(2'b00, 8'h01, 8'h01, 5, 1'b0, ok);
    send(2'b00, 8'h02, 8'h02, 5, 1'b0, ok);
    send(2'b00, 8'h03, 8'h03, 5, 1'b0, ok);
    chk("hold_valid", 32'(rsp_valid), 1);
    chk("hold_count", 32'(cmd_count), 2);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(rsp_valid), 0);
    chk("async_rst_count", 32'(cmd_count), 0);
    cycle();
    reset = 1'b0;
    rsp_ready = 1'b1;
    repeat (8) cycle();
    chk("no_stale_valid", 32'(rsp_valid), 0);

    // Faulty ALU stub: checker flag rises at the capture edge and sticks
    alu_fault = 1'b1;
    send(2'b00, 8'h10, 8'h20, 5, 1'b0, ok);
    cycle();
    chk("chk_err_pre", 32'(chk_err), 0);
    cycle();
    chk("chk_err_capture", 32'(chk_err), 32'(exp_chk));
    drain("drain_fault");
    alu_fault = 1'b0;
    send(2'b11, 8'h0C, 8'h30, 5, 1'b0, ok);
    drain("drain_after_fault");
    chk("chk_err_sticky", 32'(chk_err), 32'(exp_chk));
    reset = 1'b1;
    cycle();
    chk("chk_err_reset", 32'(chk_err), 0);
    reset = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
